eta_lock_ctrl: RTL and testbench
================================

ETA_LOCK_CTRL -- requirements
Module: eta_lock_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: cycles the locked adder is given to settle before result capture; legal range 1..15.
REQ-002 SHALL have parameter CNT_W, default 16: width of the mismatch counter.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port key_load  in  1  start serial key load.
REQ-006 SHALL have port key_sdi  in  1  serial key bit, MSB first.
REQ-007 SHALL have port key_ready  out  1  a complete key is applied to the adder.
REQ-008 SHALL have port in_valid / in_ready  in / out  1  operand handshake.
REQ-009 SHALL have ports add1_i, add2_i  in  32  operands.
REQ-010 SHALL have ports lk_add1_o, lk_add2_o  out  32  operands driven to the external locked adder.
REQ-011 SHALL have port lk_key_o  out  64  key driven to the locked adder's keyinput.
REQ-012 SHALL have port lk_result_i  in  33  locked adder result_o.
REQ-013 SHALL have port out_valid / out_ready  out / in  1  result handshake.
REQ-014 SHALL have port result_o  out  33  captured adder result.
REQ-015 SHALL have port mismatch_o  out  1  result_o differs from the exact 33-bit sum.
REQ-016 SHALL have port cnt_clr  in  1  synchronous clear of the mismatch counter.
REQ-017 SHALL have port mismatch_cnt_o  out  CNT_W  saturating mismatch count.

Function
REQ-018 SHALL implement states NOKEY, KEYSHIFT, READY, SETTLE, HOLD.
REQ-019 In NOKEY or READY, key_load=1 SHALL enter KEYSHIFT and clear the bit counter; key_load SHALL be ignored in every other state.
REQ-020 In KEYSHIFT, each cycle SHALL shift key_sdi into the LSB of the shadow key (shift left); after exactly 64 shift cycles, shadow SHALL copy to lk_key_o and the state SHALL go to READY.
REQ-021 lk_key_o SHALL change only at load completion; a partial key SHALL never reach the adder.
REQ-022 key_ready SHALL be 1 only in READY, SETTLE and HOLD.
REQ-023 in_ready SHALL be 1 only in READY; in_valid in any other state SHALL be ignored.
REQ-024 An accepted transfer (in_valid & in_ready) SHALL register add1_i/add2_i onto lk_add1_o/lk_add2_o and enter SETTLE with the settle counter loaded to SETTLE_CYCLES.
REQ-025 SETTLE SHALL last exactly SETTLE_CYCLES cycles; on its last cycle the block SHALL capture lk_result_i into result_o, set mismatch_o = (lk_result_i != {1'b0,add1}+{1'b0,add2}) with a 33-bit exact sum, and enter HOLD.
REQ-026 out_valid SHALL be 1 only in HOLD; result_o and mismatch_o SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 HOLD with out_ready=1 SHALL return to READY; the next operand SHALL be accepted no earlier than the following cycle.
REQ-028 Latency from acceptance to out_valid SHALL be SETTLE_CYCLES+1 cycles.
REQ-029 mismatch_cnt_o SHALL increment by 1 on each capture with mismatch, saturating at all-ones.
REQ-030 cnt_clr SHALL zero the counter in any state; clear SHALL win over a simultaneous increment.

Reset
REQ-031 Asserting rst SHALL immediately force NOKEY, with lk_key_o, shadow key, lk_add1_o, lk_add2_o, result_o, mismatch_o, mismatch_cnt_o, and all counters at 0, and key_ready, in_ready, out_valid at 0.
REQ-032 Reset during KEYSHIFT, SETTLE or HOLD SHALL abandon the operation with no output pulse after release.

Structure
REQ-033 A shared package SHALL hold DATA_W=32, KEY_W=64, RES_W=33 and the state enum.
REQ-034 Serial shift register, bit counter and commit logic SHALL be the sub-module eta_key_loader; the FSM, datapath and counter stay in eta_lock_ctrl.

Verification
REQ-035 Serially load 64'h5A21065A09A7176D MSB first -> lk_key_o holds 64'h5A21065A09A7176D and key_ready=1 exactly 64 cycles after KEYSHIFT entry; lk_key_o=0 until then.
REQ-036 Adder model exact; send 29AF2430+7A1B9ABC -> out_valid after SETTLE_CYCLES+1 cycles, result_o=33'h0A3CABEEC, mismatch_o=0, count 0.
REQ-037 Adder model returns 33'h0FFFFFFFE for 55555555+AAAAAAAA -> mismatch_o=1 and count=1; then cnt_clr asserted in the same cycle as a second mismatch capture -> count=0.
REQ-038 Send 00000001+DEAFBEEF with out_ready held low 5 cycles -> result_o=33'h0DEAFBEF0 stable, in_ready=0, and key_load pulses ignored throughout.
REQ-039 Assert rst mid-SETTLE and mid-KEYSHIFT -> all outputs 0, NOKEY, in_ready=0, and no out_valid after release.
REQ-040 With CNT_W=2, force 5 mismatches -> count saturates at 3.

Source files
------------

// File: rtl/eta_lock_ctrl_pkg.sv
// eta_lock_ctrl_pkg: shared widths, FSM state encoding and the exact-sum
// helper used by the locked-adder controller and its key loader.
package eta_lock_ctrl_pkg;
  localparam int DATA_W = 32;
  localparam int KEY_W  = 64;
  localparam int RES_W  = 33;
  localparam int KCNT_W = $clog2(KEY_W);
  localparam int SET_W  = 4;   // holds SETTLE_CYCLES up to 15

  typedef enum logic [2:0] {
    NOKEY,
    KEYSHIFT,
    READY,
    SETTLE,
    HOLD
  } state_e;

  // Reference sum the captured adder output is judged against.
  function automatic logic [RES_W-1:0] exact_sum(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction
endpackage

// File: rtl/eta_lock_ctrl_key_loader.sv
// eta_key_loader: serial key shift register with commit.
//   clk, rst  : clock, async active-high reset
//   start     : clear the bit counter (new load begins)
//   shift_en  : shift sdi into the shadow LSB this cycle
//   sdi       : serial key bit, MSB first
//   key       : committed key; updated only when all KEY_W bits are in
//   done      : this cycle shifts the last bit (commit happens at the edge)
module eta_key_loader
  import eta_lock_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             shift_en,
  input  logic             sdi,
  output logic [KEY_W-1:0] key,
  output logic             done
);

  logic [KEY_W-1:0]  shadow;
  logic [KCNT_W-1:0] bit_cnt;
  logic [KEY_W-1:0]  shadow_nxt;

  assign shadow_nxt = {shadow[KEY_W-2:0], sdi};
  assign done       = shift_en && (bit_cnt == KCNT_W'(KEY_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      bit_cnt <= '0;
      key     <= '0;
    end else if (start) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      shadow  <= shadow_nxt;
      bit_cnt <= bit_cnt + 1'b1;   // wraps to 0 on the last bit
      // Commit includes the bit arriving this cycle, so the adder only
      // ever sees a complete key.
      if (done) key <= shadow_nxt;
    end
  end

endmodule

// File: rtl/eta_lock_ctrl.sv
// eta_lock_ctrl: drives an external key-locked adder. Loads a 64-bit key
// serially, registers operands, waits SETTLE_CYCLES for the adder, captures
// its result and flags/counts deviations from the exact sum.
//   key_load/key_sdi/key_ready       : serial key load, key applied status
//   in_valid/in_ready/add1_i/add2_i  : operand handshake
//   lk_add1_o/lk_add2_o/lk_key_o     : drive to the locked adder
//   lk_result_i                      : locked adder result
//   out_valid/out_ready/result_o/mismatch_o : result handshake
//   cnt_clr/mismatch_cnt_o           : saturating mismatch counter
module eta_lock_ctrl
  import eta_lock_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_load,
  input  logic              key_sdi,
  output logic              key_ready,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] add1_i,
  input  logic [DATA_W-1:0] add2_i,
  output logic [DATA_W-1:0] lk_add1_o,
  output logic [DATA_W-1:0] lk_add2_o,
  output logic [KEY_W-1:0]  lk_key_o,
  input  logic [RES_W-1:0]  lk_result_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  result_o,
  output logic              mismatch_o,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  mismatch_cnt_o
);

  state_e           state, state_nxt;
  logic [SET_W-1:0] settle_cnt;
  logic             key_start, key_done, shift_en;
  logic             accept, capture, mism;

  eta_key_loader u_key (
    .clk      (clk),
    .rst      (rst),
    .start    (key_start),
    .shift_en (shift_en),
    .sdi      (key_sdi),
    .key      (lk_key_o),
    .done     (key_done)
  );

  assign shift_en  = (state == KEYSHIFT);
  assign key_ready = (state == READY) || (state == SETTLE) || (state == HOLD);
  // A key reload requested in READY takes priority; withholding ready keeps
  // that cycle from looking like an accepted operand.
  assign in_ready  = (state == READY) && !key_load;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign mism      = (lk_result_i != exact_sum(lk_add1_o, lk_add2_o));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= NOKEY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    key_start = 1'b0;
    capture   = 1'b0;
    case (state)
      NOKEY:    if (key_load) begin
                  state_nxt = KEYSHIFT;
                  key_start = 1'b1;
                end
      KEYSHIFT: if (key_done) state_nxt = READY;
      READY:    if (key_load) begin
                  state_nxt = KEYSHIFT;
                  key_start = 1'b1;
                end else if (in_valid) begin
                  state_nxt = SETTLE;
                end
      SETTLE:   if (settle_cnt == SET_W'(1)) begin
                  capture   = 1'b1;
                  state_nxt = HOLD;
                end
      HOLD:     if (out_ready) state_nxt = READY;
      default:  state_nxt = NOKEY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
      lk_add1_o  <= '0;
      lk_add2_o  <= '0;
    end else if (accept) begin
      settle_cnt <= SET_W'(SETTLE_CYCLES);
      lk_add1_o  <= add1_i;
      lk_add2_o  <= add2_i;
    end else if (state == SETTLE) begin
      settle_cnt <= settle_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_o   <= '0;
      mismatch_o <= 1'b0;
    end else if (capture) begin
      result_o   <= lk_result_i;
      mismatch_o <= mism;
    end
  end

  // Clear beats a coinciding increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      mismatch_cnt_o <= '0;
    else if (cnt_clr)                             mismatch_cnt_o <= '0;
    else if (capture && mism && !(&mismatch_cnt_o)) mismatch_cnt_o <= mismatch_cnt_o + CNT_W'(1);
  end

endmodule

// File: tb/tb_eta_lock_ctrl.sv
module tb_eta_lock_ctrl;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_load = 1'b0, key_sdi = 1'b0, in_valid = 1'b0, out_ready = 1'b0, cnt_clr = 1'b0;
  logic [31:0] add1 = '0, add2 = '0;
  logic [32:0] err_mask = '0;

  logic        key_ready, in_ready, out_valid, mismatch;
  logic [31:0] lk_add1, lk_add2;
  logic [63:0] lk_key;
  logic [32:0] lk_res, result;
  logic [15:0] cnt;

  logic        key_ready2, in_ready2, out_valid2, mismatch2;
  logic [31:0] lk_add1_2, lk_add2_2;
  logic [63:0] lk_key2;
  logic [32:0] lk_res2, result2;
  logic [1:0]  cnt2;

  // Locked adder model: exact sum, optionally corrupted by err_mask.
  assign lk_res  = ({1'b0, lk_add1} + {1'b0, lk_add2}) ^ err_mask;
  assign lk_res2 = ({1'b0, lk_add1_2} + {1'b0, lk_add2_2}) ^ err_mask;

  always #5 clk = ~clk;

  eta_lock_ctrl #(.SETTLE_CYCLES(S), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_sdi(key_sdi), .key_ready(key_ready),
    .in_valid(in_valid), .in_ready(in_ready), .add1_i(add1), .add2_i(add2),
    .lk_add1_o(lk_add1), .lk_add2_o(lk_add2), .lk_key_o(lk_key), .lk_result_i(lk_res),
    .out_valid(out_valid), .out_ready(out_ready), .result_o(result), .mismatch_o(mismatch),
    .cnt_clr(cnt_clr), .mismatch_cnt_o(cnt));

  eta_lock_ctrl #(.SETTLE_CYCLES(S), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .key_load(key_load), .key_sdi(key_sdi), .key_ready(key_ready2),
    .in_valid(in_valid), .in_ready(in_ready2), .add1_i(add1), .add2_i(add2),
    .lk_add1_o(lk_add1_2), .lk_add2_o(lk_add2_2), .lk_key_o(lk_key2), .lk_result_i(lk_res2),
    .out_valid(out_valid2), .out_ready(out_ready), .result_o(result2), .mismatch_o(mismatch2),
    .cnt_clr(cnt_clr), .mismatch_cnt_o(cnt2));

  typedef struct { logic [32:0] res; logic mis; int acc; } exp_t;
  typedef struct { int cyc; logic mis; } cap_t;

  exp_t        expq[$];
  cap_t        capq[$];
  exp_t        cur_e;
  int          cyc = 0, vecs = 0, errs = 0;
  logic [15:0] m_cnt = '0;
  logic [1:0]  m_cnt2 = '0;
  logic        m_mis;
  logic        in_hold = 1'b0;
  logic [63:0] cur_key = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference counter model: a capture happens S edges after acceptance;
  // clear wins, counts saturate at their width.
  initial forever begin
    @(posedge clk);
    cyc++;
    m_mis = 1'b0;
    if (capq.size() > 0 && capq[0].cyc == cyc) begin
      m_mis = capq[0].mis;
      void'(capq.pop_front());
    end
    if (rst || cnt_clr) begin
      m_cnt  = '0;
      m_cnt2 = '0;
    end else if (m_mis) begin
      if (m_cnt != 16'hFFFF) m_cnt++;
      if (m_cnt2 != 2'd3)    m_cnt2++;
    end
  end

  // Monitor: pops the scoreboard when a result is presented, then checks
  // it stays put until taken.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (out_valid) begin
        chk("in_ready_in_hold", 64'(in_ready), 64'(1'b0));
        chk("key_ready_in_hold", 64'(key_ready), 64'(1'b1));
        if (!in_hold) begin
          if (expq.size() == 0) begin
            chk("spurious_out_valid", 64'(out_valid), 64'(1'b0));
          end else begin
            cur_e = expq.pop_front();
            chk("latency", 64'(cyc - cur_e.acc), 64'(S + 1));
            chk("count", 64'(cnt), 64'(m_cnt));
            chk("count_w2", 64'(cnt2), 64'(m_cnt2));
          end
          in_hold = 1'b1;
        end
        chk("result", 64'(result), 64'(cur_e.res));
        chk("mismatch", 64'(mismatch), 64'(cur_e.mis));
        if (out_ready) in_hold = 1'b0;
      end else if (in_hold) begin
        chk("out_valid_dropped", 64'(out_valid), 64'(1'b1));
        in_hold = 1'b0;
      end
    end
  end

  task automatic load_key(input logic [63:0] k);
    @(posedge clk); #1 key_load = 1'b1;
    @(posedge clk); #1 key_load = 1'b0;          // KEYSHIFT entered at that edge
    for (int i = 63; i >= 0; i--) begin
      key_sdi = k[i];
      @(negedge clk);
      chk("key_ready_shift", 64'(key_ready), 64'(1'b0));
      chk("lk_key_shift", lk_key, cur_key);
      @(posedge clk); #1;
    end
    key_sdi = 1'($urandom);
    cur_key = k;
    chk("key_ready_loaded", 64'(key_ready), 64'(1'b1));
    chk("lk_key_loaded", lk_key, k);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [32:0] mask,
                      input int hold, input bit clr);
    exp_t e;
    cap_t c;
    bit   ok;
    err_mask = mask;
    @(posedge clk); #1;
    in_valid = 1'b1; add1 = a; add2 = b; out_ready = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      chk("accept_timeout", 64'(ok), 64'(1'b1));
      in_valid = 1'b0;
      return;
    end
    e.res = ({1'b0, a} + {1'b0, b}) ^ mask;
    e.mis = (mask != '0);
    e.acc = cyc;
    expq.push_back(e);
    c.cyc = cyc + 1 + S;
    c.mis = e.mis;
    capq.push_back(c);
    @(posedge clk); #1;
    in_valid = 1'b0; add1 = $urandom; add2 = $urandom;
    chk("lk_add1", 64'(lk_add1), 64'(a));
    chk("lk_add2", 64'(lk_add2), 64'(b));
    if (clr) begin
      repeat (S - 1) @(posedge clk);
      #1 cnt_clr = 1'b1;                         // sampled at the capture edge
      @(posedge clk); #1 cnt_clr = 1'b0;
    end
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("out_valid_timeout", 64'(ok), 64'(1'b1));
    repeat (hold) begin
      @(posedge clk); #1;
      key_load = 1'($urandom);
      key_sdi  = 1'($urandom);
      @(negedge clk);
    end
    @(posedge clk); #1 key_load = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    err_mask = '0;
    chk("key_kept", lk_key, cur_key);
    chk("key_ready_kept", 64'(key_ready), 64'(1'b1));
  endtask

  task automatic reset_now();
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("rst_lk_key", lk_key, 64'd0);
    chk("rst_lk_add1", 64'(lk_add1), 64'd0);
    chk("rst_lk_add2", 64'(lk_add2), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_mismatch", 64'(mismatch), 64'd0);
    chk("rst_count", 64'(cnt), 64'd0);
    chk("rst_flags", 64'({key_ready, in_ready, out_valid}), 64'd0);
    expq.delete();
    capq.delete();
    in_hold = 1'b0; cur_key = '0; m_cnt = '0; m_cnt2 = '0;
    in_valid = 1'b0; key_load = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0; err_mask = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b1;                             // must be ignored in NOKEY
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_idle", 64'({key_ready, in_ready, out_valid}), 64'd0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic [32:0] m;
    #1;
    chk("init_lk_key", lk_key, 64'd0);
    chk("init_result", 64'(result), 64'd0);
    chk("init_count", 64'(cnt), 64'd0);
    chk("init_flags", 64'({key_ready, in_ready, out_valid, mismatch}), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("nokey_in_ready", 64'(in_ready), 64'(1'b0));
    end
    in_valid = 1'b0;

    load_key(64'h5A21065A09A7176D);
    send(32'h29AF2430, 32'h7A1B9ABC, 33'h0, 0, 1'b0);
    send(32'h55555555, 32'hAAAAAAAA, 33'h1, 1, 1'b0);
    send(32'h12345678, 32'h9ABCDEF0, 33'h100, 0, 1'b1);
    send(32'h00000001, 32'hDEAFBEEF, 33'h0, 5, 1'b0);

    for (int i = 0; i < 5; i++) send($urandom, $urandom, 33'h1 << (i * 3), 0, 1'b0);
    @(negedge clk);
    chk("sat_w2", 64'(cnt2), 64'd3);
    chk("cnt_5", 64'(cnt), 64'(m_cnt));

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) load_key({$urandom, $urandom});
      m = {1'($urandom), 32'($urandom)};
      if (m == '0) m = 33'h1;
      send($urandom, $urandom, ($urandom_range(0, 2) == 0) ? m : 33'h0,
           $urandom_range(0, 3), $urandom_range(0, 5) == 0);
    end

    // Reset mid-SETTLE.
    @(posedge clk); #1 in_valid = 1'b1; add1 = $urandom; add2 = $urandom;
    @(posedge clk); #1 in_valid = 1'b0;
    reset_now();

    // Reset mid-KEYSHIFT.
    @(posedge clk); #1 key_load = 1'b1;
    @(posedge clk); #1 key_load = 1'b0;
    repeat (20) begin key_sdi = 1'($urandom); @(posedge clk); #1; end
    reset_now();

    load_key({$urandom, $urandom});
    for (int i = 0; i < 6; i++) send($urandom, $urandom, (i % 2) ? 33'h4 : 33'h0, i % 3, 1'b0);

    repeat (4) @(posedge clk);
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
